// File: rtl/hrange_pkg.sv
// hrange_pkg: shared definitions for the hrange_lanes range generator.
//   state_t : generator state (DONE = exhausted/idle, RUN = emitting beats)
//   EXT     : guard bits added above WIDTH for all range arithmetic, so that
//             base + k*step and i0 + LANES*step never wrap into a false
//             in-range value (LANES <= 8 needs at most 4 extra bits).
package hrange_pkg;

    localparam int EXT = 4;

    typedef enum logic {
        DONE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/hrange_lane.sv
// hrange_lane: one lane of the range generator.
// Computes val = base_i + K*step_i in WIDTH+EXT signed arithmetic and flags
// whether it lies strictly inside the range bounded by limit_i in the
// direction of step_i.
//   base_i  : sign-extended first element of the beat
//   step_i  : sign-extended stride
//   limit_i : sign-extended exclusive bound
//   val_o   : lane value truncated to WIDTH, forced to 0 when out of range
//   ok_o    : lane value is in range
module hrange_lane
    import hrange_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic signed [WIDTH+EXT-1:0] base_i,
    input  logic signed [WIDTH+EXT-1:0] step_i,
    input  logic signed [WIDTH+EXT-1:0] limit_i,
    output logic        [WIDTH-1:0]     val_o,
    output logic                        ok_o
);

    localparam int XW = WIDTH + EXT;
    localparam logic signed [XW-1:0] KX = XW'(K);

    logic signed [XW-1:0] val;
    logic                 in_bound;
    logic                 fits;

    assign val = base_i + step_i * KX;

    // Direction taken from the stride's sign bit; a zero stride is never in range.
    always_comb begin
        in_bound = 1'b0;
        if (|step_i) begin
            if (step_i[XW-1]) begin
                in_bound = (val > limit_i);
            end else begin
                in_bound = (val < limit_i);
            end
        end
    end

    // Guard bits must be a pure sign extension for the value to be emitted.
    assign fits  = (&val[XW-1:WIDTH-1]) || !(|val[XW-1:WIDTH-1]);
    assign ok_o  = in_bound && fits;
    assign val_o = ok_o ? val[WIDTH-1:0] : '0;

endmodule

// File: rtl/hrange_lanes.sv
// hrange_lanes: multi-lane arithmetic range generator.
// Emits base, base+step, ... while the element is below limit (step > 0) or
// above limit (step < 0), packing LANES consecutive elements into each beat
// over a valid/ready handshake.
//   _clock  : rising-edge clock
//   _reset  : synchronous active-low reset
//   _start  : one-cycle pulse capturing base/limit/step (restarts when busy)
//   base    : signed first element
//   limit   : signed exclusive bound
//   step    : signed stride
//   _ready  : consumer accepts the current beat
//   _valid  : _out/_mask hold a beat
//   _out    : lane k in bits [k*WIDTH +: WIDTH]
//   _mask   : contiguous in-range lanes starting at lane 0
//   _done   : generator exhausted and idle
module hrange_lanes
    import hrange_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 2
) (
    input  logic                     _clock,
    input  logic                     _reset,
    input  logic                     _start,
    input  logic signed [WIDTH-1:0]  base,
    input  logic signed [WIDTH-1:0]  limit,
    input  logic signed [WIDTH-1:0]  step,
    input  logic                     _ready,
    output logic                     _valid,
    output logic [LANES*WIDTH-1:0]   _out,
    output logic [LANES-1:0]         _mask,
    output logic                     _done
);

    localparam int XW = WIDTH + EXT;
    localparam logic signed [XW-1:0] LX = XW'(LANES);

    state_t                   state_q, state_d;
    logic signed [XW-1:0]     i0_q, i0_d;
    logic signed [XW-1:0]     step_q, step_d;
    logic signed [XW-1:0]     limit_q, limit_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic [LANES*WIDTH-1:0]   out_q, out_d;
    logic [LANES-1:0]         mask_q, mask_d;

    logic signed [XW-1:0]     base_x, step_x, limit_x;
    logic signed [XW-1:0]     src_base, src_step, src_limit;
    logic [LANES*WIDTH-1:0]   lane_val;
    logic [LANES-1:0]         lane_ok;
    logic                     advance;

    assign base_x  = {{EXT{base[WIDTH-1]}}, base};
    assign step_x  = {{EXT{step[WIDTH-1]}}, step};
    assign limit_x = {{EXT{limit[WIDTH-1]}}, limit};

    assign advance = (state_q == RUN) && valid_q && _ready;

    // Lanes always evaluate the beat that would be loaded next: the freshly
    // captured inputs on _start, otherwise the beat following the current one.
    assign src_base  = _start ? base_x  : (i0_q + step_q * LX);
    assign src_step  = _start ? step_x  : step_q;
    assign src_limit = _start ? limit_x : limit_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        hrange_lane #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_lane (
            .base_i  (src_base),
            .step_i  (src_step),
            .limit_i (src_limit),
            .val_o   (lane_val[k*WIDTH +: WIDTH]),
            .ok_o    (lane_ok[k])
        );
    end

    always_comb begin
        state_d = state_q;
        i0_d    = i0_q;
        step_d  = step_q;
        limit_d = limit_q;
        valid_d = valid_q;
        out_d   = out_q;
        mask_d  = mask_q;

        if (_start || advance) begin
            step_d  = src_step;
            limit_d = src_limit;
            // The sequence is monotonic, so lane 0 decides whether any beat remains.
            if (lane_ok[0]) begin
                state_d = RUN;
                i0_d    = src_base;
                valid_d = 1'b1;
                out_d   = lane_val;
                mask_d  = lane_ok;
            end else begin
                state_d = DONE;
                valid_d = 1'b0;
                out_d   = '0;
                mask_d  = '0;
            end
        end

        done_d = (state_d == DONE) && !valid_d;
    end

    always_ff @(posedge _clock) begin
        if (!_reset) begin
            state_q <= DONE;
            i0_q    <= '0;
            step_q  <= '0;
            limit_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            i0_q    <= i0_d;
            step_q  <= step_d;
            limit_q <= limit_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            out_q   <= out_d;
            mask_q  <= mask_d;
        end
    end

    assign _valid = valid_q;
    assign _out   = out_q;
    assign _mask  = mask_q;
    assign _done  = done_q;

endmodule

// File: tb/tb_hrange_lanes.sv
// Testbench for hrange_lanes: a queue-based reference model of the expected
// beats is compared against a WIDTH=32/LANES=2 instance on every cycle, with
// directed literal checks and a WIDTH=8 instance for wrap-around bounds.
module tb_hrange_lanes;

    localparam int W = 32;
    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, start, ready;
    logic signed [31:0]  base, limit, step;
    logic                valid, done;
    logic [63:0]         out;
    logic [1:0]          mask;

    logic                start8;
    logic signed [7:0]   base8, limit8, step8;
    logic                valid8, done8;
    logic [15:0]         out8;
    logic [1:0]          mask8;

    hrange_lanes #(.WIDTH(32), .LANES(2)) dut (
        ._clock (clk),   ._reset (rst_n), ._start (start),
        .base   (base),  .limit  (limit), .step   (step),
        ._ready (ready), ._valid (valid), ._out   (out),
        ._mask  (mask),  ._done  (done)
    );

    hrange_lanes #(.WIDTH(8), .LANES(2)) dut8 (
        ._clock (clk),    ._reset (rst_n),  ._start (start8),
        .base   (base8),  .limit  (limit8), .step   (step8),
        ._ready (ready),  ._valid (valid8), ._out   (out8),
        ._mask  (mask8),  ._done  (done8)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] out;
        logic [1:0]  mask;
    } beat_t;

    beat_t exp_q[$];
    bit    exp_done = 1'b0;

    // Enumerate the range with exact 64-bit arithmetic, then pack L per beat.
    function automatic void build(input longint b, input longint l, input longint s,
                                  output beat_t q[$]);
        longint      el[$];
        longint      i;
        logic [63:0] tmp;
        beat_t       bt;
        q.delete();
        i = b;
        while (el.size() < 64 && ((s > 0 && i < l) || (s < 0 && i > l))) begin
            el.push_back(i);
            i += s;
        end
        for (int n = 0; n < el.size(); n += L) begin
            bt.out  = '0;
            bt.mask = '0;
            for (int k = 0; k < L; k++) begin
                if (n + k < el.size()) begin
                    tmp = el[n+k];
                    bt.out[k*W +: W] = tmp[W-1:0];
                    bt.mask[k] = 1'b1;
                end
            end
            q.push_back(bt);
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            if (start) begin
                build(base, limit, step, exp_q);
            end else if (exp_q.size() > 0 && ready) begin
                void'(exp_q.pop_front());
            end
            exp_done = (exp_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        chk("valid", valid, exp_q.size() > 0);
        chk("done", done, exp_done);
        if (exp_q.size() > 0) begin
            chk("out", out, exp_q[0].out);
            chk("mask", mask, exp_q[0].mask);
        end else begin
            chk("out_idle", out, 64'd0);
            chk("mask_idle", mask, 64'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic go(input longint b, input longint l, input longint s);
        start = 1'b1;
        base  = 32'(b);
        limit = 32'(l);
        step  = 32'(s);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go8(input int b, input int l, input int s);
        start8 = 1'b1;
        base8  = 8'(b);
        limit8 = 8'(l);
        step8  = 8'(s);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic rand_params();
        longint b, l, s, d, mag;
        longint n, off;
        if ($urandom % 4 != 0) begin
            mag = 1 + longint'($urandom % 9);
            s   = ($urandom % 2) ? mag : -mag;
            if ($urandom % 15 == 0) s = 0;
            b   = longint'($urandom % 201) - 100;
            n   = longint'($urandom % 10);
            off = longint'($urandom) % mag;
            l   = (s >= 0) ? b + s * n + off : b + s * n - off;
        end else begin
            b = longint'($signed($urandom));
            l = longint'($signed($urandom));
            d = (l > b) ? l - b : b - l;
            mag = d / (1 + longint'($urandom % 12)) + longint'($urandom % 1000);
            if (mag > 64'sd2147483647) mag = 64'sd2147483647;
            if (mag == 0) mag = 1;
            s = ((l > b) ^ ($urandom % 6 == 0)) ? mag : -mag;
        end
        start = 1'b1;
        base  = 32'(b);
        limit = 32'(l);
        step  = 32'(s);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        beat_t pq[$];
        int    waited;

        rst_n = 1'b0; start = 1'b0; ready = 1'b1;
        base = '0; limit = '0; step = '0;
        start8 = 1'b0; base8 = '0; limit8 = '0; step8 = '0;

        // Model pinned against hand-computed beats.
        build(0, 10, 2, pq);
        chk("model_asc_size", pq.size(), 3);
        chk("model_asc_last", pq[2].out, 64'h00000000_00000008);
        chk("model_asc_lastm", pq[2].mask, 2'b01);
        build(10, 0, -3, pq);
        chk("model_desc_size", pq.size(), 2);
        chk("model_desc_b1", pq[1].out, 64'h00000001_00000004);
        build(5, 5, 1, pq);
        chk("model_empty", pq.size(), 0);

        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_out", out, 0);
        chk("rst_mask", mask, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_done", done, 1);

        // Ascending 0..10 step 2
        go(0, 10, 2);
        chk("asc_b0", out, 64'h00000002_00000000); chk("asc_m0", mask, 2'b11);
        chk("asc_v0", valid, 1);
        @(negedge clk);
        chk("asc_b1", out, 64'h00000006_00000004); chk("asc_m1", mask, 2'b11);
        @(negedge clk);
        chk("asc_b2", out, 64'h00000000_00000008); chk("asc_m2", mask, 2'b01);
        @(negedge clk);
        chk("asc_end_v", valid, 0); chk("asc_end_d", done, 1);

        // Descending 10..0 step -3
        go(10, 0, -3);
        chk("desc_b0", out, 64'h00000007_0000000A); chk("desc_m0", mask, 2'b11);
        @(negedge clk);
        chk("desc_b1", out, 64'h00000001_00000004); chk("desc_m1", mask, 2'b11);
        @(negedge clk);
        chk("desc_end_d", done, 1);

        // Restart from RUN into step==0, then an empty range
        go(0, 100, 1);
        chk("rs_v", valid, 1);
        go(3, 10, 0);
        chk("step0_v", valid, 0); chk("step0_d", done, 1);
        go(5, 5, 1);
        chk("empty_v", valid, 0); chk("empty_d", done, 1);

        // Back-pressure on beat (4,6)
        go(0, 10, 2);
        @(negedge clk);
        ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", out, 64'h00000006_00000004);
            chk("bp_hold_v", valid, 1);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("bp_resume", out, 64'h00000000_00000008); chk("bp_resume_m", mask, 2'b01);
        @(negedge clk);
        chk("bp_end_d", done, 1);

        // 8-bit bounds near the wrap point
        go8(120, 127, 5);
        chk("w8_b0", out8, 16'h7D78); chk("w8_m0", mask8, 2'b11);
        @(negedge clk);
        chk("w8_end_v", valid8, 0); chk("w8_end_d", done8, 1);
        go8(-120, -128, -5);
        chk("w8n_b0", out8, 16'h8388); chk("w8n_m0", mask8, 2'b11);
        @(negedge clk);
        chk("w8n_end_v", valid8, 0); chk("w8n_end_d", done8, 1);

        // Reset together with start mid-sequence
        go(0, 100, 1);
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; base = 7; limit = 50; step = 1;
        @(negedge clk);
        chk("rs_mid_v", valid, 0); chk("rs_mid_d", done, 0); chk("rs_mid_o", out, 0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("rs_rel_d", done, 1); chk("rs_rel_v", valid, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            ready = ($urandom % 4) != 0;
            start = 1'b0;
            if ($urandom % 10 == 0) rand_params();
            rst_n = ($urandom % 150 != 0);
            @(negedge clk);
        end
        start = 1'b0; rst_n = 1'b1; ready = 1'b1;
        waited = 0;
        while (!done && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_done", done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hrange_lanes.md
HRANGE_LANES -- requirements
Module: hrange_lanes

Interface
REQ-001 Parameter WIDTH, default 32: signed width of base, limit, step and each output lane.
REQ-002 Parameter LANES, default 2: number of range elements emitted per output beat (1..8).
REQ-003 Port _clock, input, 1: single clock, all logic on rising edge.
REQ-004 Port _reset, input, 1: reset is synchronous and active-low.
REQ-005 Port _start, input, 1: high for one cycle to capture base/limit/step and begin generating.
REQ-006 Port base, input, WIDTH: signed first value, sampled only when _start is high.
REQ-007 Port limit, input, WIDTH: signed exclusive bound, sampled only when _start is high.
REQ-008 Port step, input, WIDTH: signed stride, sampled only when _start is high.
REQ-009 Port _ready, input, 1: consumer accepts the current beat.
REQ-010 Port _valid, output, 1: _out and _mask hold a valid beat.
REQ-011 Port _out, output, LANES*WIDTH: lane k in bits [k*WIDTH +: WIDTH].
REQ-012 Port _mask, output, LANES: bit k set when lane k holds an in-range value.
REQ-013 Port _done, output, 1: high while the generator is exhausted and idle.

Function
REQ-014 The block SHALL emit the sequence i = base, base+step, ... while i<limit (step>0) or i>limit (step<0), packing LANES consecutive elements per beat.
REQ-015 Lane k of a beat SHALL equal i0 + k*step, where i0 is the beat's first element; all range compares SHALL use WIDTH+4-bit sign-extended arithmetic, so wrap-around never produces a false in-range value.
REQ-016 _mask SHALL be a contiguous run of ones from lane 0; lanes with a clear mask bit SHALL drive 0.
REQ-017 After each accepted beat, i0 SHALL advance by LANES*step; when the lane-0 element of the next beat is out of range, the block SHALL enter DONE.
REQ-018 States: DONE, RUN. DONE->RUN on _start with a non-empty range and nonzero step. RUN->DONE after the final beat is accepted. _start in RUN SHALL restart with the new inputs.
REQ-019 When _start captures inputs, the first beat SHALL present _valid=1 on the following cycle (latency 1).
REQ-020 Captured inputs with an empty range or step==0 SHALL keep the block in DONE with no _valid; _done SHALL be 1 on the following cycle.
REQ-021 Handshake: a beat transfers on a cycle where _valid&&_ready; while _valid&&!_ready, _out, _mask and _valid SHALL hold unchanged.
REQ-022 After a transfer, the next beat SHALL present with no bubble (back-to-back throughput of one beat per cycle).
REQ-023 _done SHALL be 1 only in DONE with _valid=0, and never in the same cycle as _valid=1.

Reset
REQ-024 Reset (_reset==0 at the clock edge) SHALL force state DONE, _valid=0, _done=0, _out=0, _mask=0, and internal registers to 0.
REQ-025 _done SHALL rise on the first clock after _reset returns high.
REQ-026 Reset SHALL take precedence over a simultaneous _start; an in-flight beat is dropped.

Structure
REQ-027 Package hrange_pkg SHALL hold the state enum {DONE, RUN} and the guard-width constant EXT=4.
REQ-028 One sub-module, hrange_lane, SHALL compute a single lane value and its in-range flag; it is instantiated LANES times via generate.

Verification
REQ-029 Test WIDTH=32, LANES=2, base=0, limit=10, step=2, _ready=1: beats (0,2) m=11; (4,6) m=11; (8,0) m=01; then _done=1.
REQ-030 Test descending input base=10, limit=0, step=-3: beats (10,7) m=11 and (4,1) m=11, then _done.
REQ-031 Test step=0 or base=limit=5: no _valid; _done=1 one cycle after _start.
REQ-032 Test back-pressure with _ready=0 for 3 cycles on beat (4,6): beat held stable, then the sequence resumes unchanged.
REQ-033 Test WIDTH=8, base=120, limit=127, step=5: beat (120,125) m=11 only, then _done; no wrapped negative value appears.
REQ-034 Test _reset=0 pulsed mid-sequence alongside _start: _valid=0 next cycle, _done=1 after reset release, no beat emitted.
